// File: rtl/pipe_pkg.sv
// Shared definitions for the reusable pipeline stage register.
// Default widths and the payload layout carried through a stage.
package pipe_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int RD_W_DEF        = 5;
    localparam int STALL_CNT_W_DEF = 16;

    // One beat as it travels between stages (default widths).
    // Inside the stage the same fields are packed MSB-first as
    // {data, rd, reg_en}, so a flat vector and this struct line up.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [RD_W_DEF-1:0]   rd;
        logic                  reg_en;
    } pipe_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-slot skid buffer sitting behind the main stage register.
// Holds a single parked beat plus an empty flag. The flag is itself a
// flop, so the upstream ready derived from it has no combinational
// path back from the downstream side.
module pipe_skid_buf #(
    parameter int PAY_W = 38
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [PAY_W-1:0] pay_i,
    output logic [PAY_W-1:0] pay_o,
    output logic             empty_o
);

    logic             empty_q;
    logic [PAY_W-1:0] pay_q;

    // Park a beat on load, release it on unload; clear drops it outright.
    always_ff @(posedge clock) begin
        if (!reset) begin
            empty_q <= 1'b1;
            pay_q   <= '0;
        end else if (clear_i) begin
            empty_q <= 1'b1;
        end else if (load_i) begin
            empty_q <= 1'b0;
            pay_q   <= pay_i;
        end else if (unload_i) begin
            empty_q <= 1'b1;
        end
    end

    assign pay_o   = pay_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush,
// write-enable bubble qualification and a saturating stall counter.
// Optional feature macro: PIPE_SKID_EN adds a one-entry skid buffer and
// turns ready_out into a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int RD_W        = RD_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [RD_W-1:0]        rd_in,
    input  logic                   reg_en_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [DATA_W-1:0]      data_out,
    output logic [RD_W-1:0]        rd_out,
    output logic                   reg_en_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int PAY_W = DATA_W + RD_W + 1;
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    logic                   valid_q, valid_d;
    logic [PAY_W-1:0]       main_q, main_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [PAY_W-1:0]       in_pay;
    logic                   up_xfer;
    logic                   dn_xfer;

    assign in_pay  = {data_in, rd_in, reg_en_in};
    assign up_xfer = valid_in && ready_out;
    assign dn_xfer = valid_q && ready_in;

`ifdef PIPE_SKID_EN
    logic             skid_load;
    logic             skid_unload;
    logic             skid_empty;
    logic [PAY_W-1:0] skid_pay;

    // A beat accepted while the main register is full and not draining
    // must park in the skid slot; it leaves when the main beat drains.
    assign skid_load   = up_xfer && valid_q && !ready_in && !flush;
    assign skid_unload = dn_xfer && !skid_empty && !flush;

    pipe_skid_buf #(
        .PAY_W (PAY_W)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (flush),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .pay_i    (in_pay),
        .pay_o    (skid_pay),
        .empty_o  (skid_empty)
    );

    // Upstream may push whenever the skid slot is free.
    assign ready_out = skid_empty;

    // Main register refills from skid first to keep beats in order.
    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!valid_q || dn_xfer) begin
            if (!skid_empty) begin
                valid_d = 1'b1;
                main_d  = skid_pay;
            end else if (up_xfer) begin
                valid_d = 1'b1;
                main_d  = in_pay;
            end else begin
                valid_d = 1'b0;
            end
        end
    end
`else
    // Room exists when empty or when the held beat leaves this cycle.
    assign ready_out = ready_in || !valid_q;

    // Single register: load on accept, empty on drain without refill.
    always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (up_xfer) begin
            valid_d = 1'b1;
            main_d  = in_pay;
        end else if (dn_xfer) begin
            valid_d = 1'b0;
        end
    end
`endif

    // Count stalled cycles independently of flush; stick at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !ready_in && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State update; data/rd are left untouched by flush and drain.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            main_q  <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_d;
            main_q  <= main_d;
            stall_q <= stall_d;
        end
    end

    assign valid_out  = valid_q;
    assign data_out   = main_q[PAY_W-1 -: DATA_W];
    assign rd_out     = main_q[RD_W:1];
    // Qualify the write enable so an empty stage can never write.
    assign reg_en_out = main_q[0] && valid_q;
    assign stall_cnt  = stall_q;

endmodule
